idex_hazard_ctrl: RTL and testbench
===================================

IDEX_HAZARD_CTRL -- requirements
Module: idex_hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and one reset; reset is synchronous and active-low.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 nRST  in  1  synchronous active-low reset, sampled on the CLK rising edge.
REQ-004 ihit  in  1  instruction fetch for the current PC has completed this cycle.
REQ-005 dhit  in  1  data access for the EX/MEM stage has completed this cycle.
REQ-006 exmem_dmem  in  1  EX/MEM holds a data access (dREN or dWEN).
REQ-007 idex_dREN  in  1  ID/EX dREN_o; the instruction in EX is a load.
REQ-008 idex_rt  in  5  ID/EX rt_o; load destination register.
REQ-009 ifid_rs, ifid_rt  in  5 each  source registers of the instruction in decode.
REQ-010 ifid_uses_rt  in  1  the decode instruction reads rt as a source.
REQ-011 ex_redirect  in  1  a taken branch or jump resolves in EX this cycle.
REQ-012 exmem_halt  in  1  EX/MEM halt_o.
REQ-013 pc_en, ifid_en, idex_en, exmem_en  out  1 each  stage advance enables.
REQ-014 ifid_flush, idex_flush  out  1 each  load a bubble into IF/ID or ID/EX (the flush input of the ID/EX register).
REQ-015 halted  out  1  registered; the pipeline is permanently frozen.
REQ-016 stall_count  out  32  registered count of cycles with pc_en=0 while not halted.

Function
REQ-017 The block SHALL hold a state register with encodings RUN, MEM_WAIT, LU_STALL, HALTED.
REQ-018 Enables and flushes SHALL be combinational from state and inputs, with priority (highest first) per REQ-019..REQ-024.
REQ-019 HALTED: all enables=0; all flushes=0; halted=1; the state is held until reset.
REQ-020 Memory wait (exmem_dmem=1, dhit=0): all enables=0; all flushes=0; next state MEM_WAIT.
REQ-021 Redirect (ex_redirect=1): all enables=1; ifid_flush=1; idex_flush=1; next state RUN; a coincident load-use is ignored.
REQ-022 Load-use (state!=LU_STALL, idex_dREN=1, idex_rt!=0, and ifid_rs==idex_rt or (ifid_uses_rt=1 and ifid_rt==idex_rt)): pc_en=0; ifid_en=0; idex_en=1; idex_flush=1; exmem_en=1; next state LU_STALL.
REQ-023 Fetch miss (ihit=0): pc_en=0; ifid_en=1; ifid_flush=1; idex_en=1; exmem_en=1; next state RUN.
REQ-024 Otherwise: all enables=1; no flushes; next state RUN.
REQ-025 LU_STALL SHALL last exactly one cycle and SHALL suppress load-use detection in that cycle only; the other rules still apply.
REQ-026 Halt: exmem_halt=1 in a cycle not frozen by REQ-020 SHALL give next state HALTED, taking precedence over REQ-021..REQ-024 for the next-state choice. The current-cycle outputs still follow the normal rules.
REQ-027 MEM_WAIT SHALL exit in the first cycle with dhit=1. In that cycle outputs are decided by REQ-021..REQ-024.
REQ-028 stall_count SHALL increment by 1 on each edge where the cycle had pc_en=0 and state!=HALTED. It saturates at 0xFFFFFFFF and does not wrap.
REQ-029 Register $0 (idex_rt==0) SHALL never cause a load-use stall.

Reset
REQ-030 With nRST=0 at a rising edge: state=RUN, halted=0, stall_count=0.
REQ-031 Outputs in the reset cycle SHALL be those of state RUN given the current inputs; reset SHALL override any pending halt, wait or stall.
REQ-032 Reset asserted mid-MEM_WAIT or mid-LU_STALL SHALL return the block to RUN on that edge, with no residual suppression.

Verification
REQ-033 idex_dREN=1, idex_rt=8, ifid_rs=8, ihit=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1, then RUN with all enables=1; stall_count=1.
REQ-034 exmem_dmem=1, dhit=0 for 3 cycles, then dhit=1 -> all enables=0 for 3 cycles, then all=1; stall_count=3.
REQ-035 ex_redirect=1 together with a load-use match -> ifid_flush=1, idex_flush=1, pc_en=1; no LU_STALL; stall_count unchanged.
REQ-036 idex_rt=0, ifid_rs=0, idex_dREN=1 -> no stall; all enables=1.
REQ-037 exmem_halt=1 -> halted=1 next cycle; enables stay 0 for 10 cycles; stall_count frozen; nRST=0 -> state RUN, stall_count=0.
REQ-038 Preload stall_count near saturation (force 0xFFFFFFFE), then hold ihit=0 for 3 cycles -> stall_count reaches 0xFFFFFFFF and stays there.

Source files
------------

// File: rtl/idex_hazard_ctrl.sv
// Pipeline hazard controller: stage enables and flushes for memory waits,
// load-use stalls, fetch misses, EX redirects and halt, plus a stall-cycle counter.
module idex_hazard_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        exmem_dmem,
    input  logic        idex_dREN,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic        ex_redirect,
    input  logic        exmem_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic [31:0] stall_count,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        LU_STALL = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t state;
    state_t next_state;
    state_t eff_state;
    logic   lu_hit;

    // During the reset cycle the outputs behave as RUN, so a pending halt,
    // wait or load-use suppression cannot leak into that cycle.
    always_comb begin
        eff_state = nRST ? state : RUN;
    end

    always_comb begin
        lu_hit = idex_dREN && (idex_rt != 5'd0) &&
                 ((ifid_rs == idex_rt) || (ifid_uses_rt && (ifid_rt == idex_rt)));
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        next_state = RUN;
        if (eff_state == HALTED) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            next_state = HALTED;
        end else if (exmem_dmem && !dhit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            next_state = MEM_WAIT;
        end else begin
            if (ex_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if ((eff_state != LU_STALL) && lu_hit) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                next_state = LU_STALL;
            end else if (!ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
            // Halt only steers the next state; this cycle's outputs stand.
            if (exmem_halt) begin
                next_state = HALTED;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            state  <= next_state;
            halted <= (next_state == HALTED);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_count <= 32'd0;
        end else if ((state != HALTED) && !pc_en && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Bench for idex_hazard_ctrl: single-cycle vector table plus multi-cycle sequences
// for stalls, memory waits, halt, reset recovery and counter saturation.
module tb_idex_hazard_ctrl;

    typedef struct {
        logic       ihit;
        logic       dhit;
        logic       dmem;
        logic       dren;
        logic [4:0] xrt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       redir;
        logic       halt;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [5:0] exp;
    } vec_t;

    // Expected {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}
    localparam logic [5:0] ALL1  = 6'b111100;
    localparam logic [5:0] ALL0  = 6'b000000;
    localparam logic [5:0] REDIR = 6'b111111;
    localparam logic [5:0] LU    = 6'b001101;
    localparam logic [5:0] MISS  = 6'b011110;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b1;
    logic        dhit = 1'b0;
    logic        exmem_dmem = 1'b0;
    logic        idex_dREN = 1'b0;
    logic [4:0]  idex_rt = 5'd0;
    logic [4:0]  ifid_rs = 5'd0;
    logic [4:0]  ifid_rt = 5'd0;
    logic        ifid_uses_rt = 1'b0;
    logic        ex_redirect = 1'b0;
    logic        exmem_halt = 1'b0;
    logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, halted;
    logic [31:0] stall_count;
    logic [1:0]  fsm_state;

    logic [5:0]  exp_q[$];
    logic [31:0] exp_stall = 32'd0;
    logic        exp_halted = 1'b0;
    int          tests_run = 0;
    int          tests_failed = 0;

    idex_hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dmem(exmem_dmem),
        .idex_dREN(idex_dREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .ex_redirect(ex_redirect), .exmem_halt(exmem_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
        .stall_count(stall_count), .fsm_state(fsm_state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic stim_t mk(input logic ih, input logic dh, input logic dm, input logic dr,
                                 input logic [4:0] xrt, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic ur, input logic rd, input logic hl);
        stim_t s;
        s.ihit = ih; s.dhit = dh; s.dmem = dm; s.dren = dr;
        s.xrt = xrt; s.rs = rs; s.rt = rt;
        s.uses_rt = ur; s.redir = rd; s.halt = hl;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, then registered ones.
    task automatic step(input string name, input logic rst_val, input stim_t s,
                        input logic [5:0] exp, input logic halt_after);
        logic [5:0] want;
        @(negedge CLK);
        nRST = rst_val;
        ihit = s.ihit; dhit = s.dhit; exmem_dmem = s.dmem; idex_dREN = s.dren;
        idex_rt = s.xrt; ifid_rs = s.rs; ifid_rt = s.rt; ifid_uses_rt = s.uses_rt;
        ex_redirect = s.redir; exmem_halt = s.halt;
        exp_q.push_back(exp);
        if (!rst_val) exp_stall = 32'd0;
        else if (!exp_halted && !exp[5] && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
        #2;
        want = exp_q.pop_front();
        check({name, ".en"}, {26'd0, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush},
              {26'd0, want});
        @(posedge CLK);
        #1;
        exp_halted = halt_after;
        check({name, ".stall_count"}, stall_count, exp_stall);
        check({name, ".halted"}, {31'd0, halted}, {31'd0, exp_halted});
    endtask

    vec_t  tbl[14];
    stim_t idle, lu8, mw;

    initial begin
        idle = mk(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        lu8  = mk(1, 0, 0, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0);
        mw   = mk(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

        tbl[0]  = '{"idle",          idle,                                     ALL1};
        tbl[1]  = '{"lu_rs",         lu8,                                      LU};
        tbl[2]  = '{"lu_rt",         mk(1, 0, 0, 1, 5'd9, 5'd1, 5'd9, 1, 0, 0),  LU};
        tbl[3]  = '{"rt_not_used",   mk(1, 0, 0, 1, 5'd9, 5'd1, 5'd9, 0, 0, 0),  ALL1};
        tbl[4]  = '{"r0_no_stall",   mk(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0),  ALL1};
        tbl[5]  = '{"no_load",       mk(1, 0, 0, 0, 5'd8, 5'd8, 5'd8, 1, 0, 0),  ALL1};
        tbl[6]  = '{"fetch_miss",    mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0),  MISS};
        tbl[7]  = '{"redir_lu",      mk(1, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0),  REDIR};
        tbl[8]  = '{"redir_miss",    mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0),  REDIR};
        tbl[9]  = '{"mem_wait",      mw,                                       ALL0};
        tbl[10] = '{"mem_wait_redir", mk(1, 0, 1, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0), ALL0};
        tbl[11] = '{"mem_hit",       mk(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0),  ALL1};
        tbl[12] = '{"lu_over_miss",  mk(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0),  LU};
        tbl[13] = '{"mem_hit_lu",    mk(1, 1, 1, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0),  LU};

        step("reset0", 0, idle, ALL1, 0);
        step("reset1", 0, lu8, LU, 0);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].name, 1, tbl[i].s, tbl[i].exp, 0);
            step({tbl[i].name, ".idle"}, 1, idle, ALL1, 0);
        end

        // Load-use stalls exactly one cycle; the following cycle is suppressed.
        step("lu_seq.stall", 1, lu8, LU, 0);
        step("lu_seq.suppressed", 1, lu8, ALL1, 0);
        step("lu_seq.again", 1, lu8, LU, 0);
        step("lu_seq.miss_in_stall", 1, mk(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0), MISS, 0);
        step("lu_seq.idle", 1, idle, ALL1, 0);

        for (int i = 0; i < 3; i++) step("mw_seq.wait", 1, mw, ALL0, 0);
        step("mw_seq.exit", 1, mk(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0), ALL1, 0);

        // Halt inside a memory wait is ignored; the freeze wins.
        step("mw_halt.frozen", 1, mk(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1), ALL0, 0);
        step("mw_halt.exit", 1, mk(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0), ALL1, 0);

        step("halt.req", 1, mk(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1), ALL1, 1);
        for (int i = 0; i < 10; i++) begin
            stim_t r;
            r = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            step("halt.frozen", 1, r, ALL0, 1);
        end
        step("halt.reset", 0, idle, ALL1, 0);
        check("halt.reset.state", {30'd0, fsm_state}, 32'd0);
        step("halt.resume", 1, idle, ALL1, 0);

        // Reset mid-LU_STALL clears the suppression.
        step("rst_lu.stall", 1, lu8, LU, 0);
        step("rst_lu.reset", 0, lu8, LU, 0);
        step("rst_lu.detect", 1, lu8, LU, 0);
        step("rst_lu.idle", 1, idle, ALL1, 0);

        step("rst_mw.wait", 1, mw, ALL0, 0);
        step("rst_mw.reset", 0, mw, ALL0, 0);
        check("rst_mw.state", {30'd0, fsm_state}, 32'd0);
        step("rst_mw.idle", 1, idle, ALL1, 0);

        force dut.stall_count = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count;
        exp_stall = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step("sat.miss", 1, mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0), MISS, 0);
        step("sat.idle", 1, idle, ALL1, 0);
        check("sat.value", stall_count, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
